// File: rtl/tank_level_emulator.sv
// -----------------------------------------------------------------------------
// tank_level_emulator
//
// Closed-loop water-tank model. It integrates a tank level from the
// irrigation controller's valve commands and drives the high/middle/low
// level sensors back to the controller. Fault injection forces one
// sensor to a stuck value so that the controller's alarm paths can be
// exercised.
//
// Ports:
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   valvula_entrada     inlet valve open (adds FILL_RATE per tick)
//   valvula_aspersao    sprinkler valve open (removes SPR_RATE per tick)
//   valvula_gotejamento drip valve open (removes DRIP_RATE per tick)
//   load_en             force level to load_value (clamped to TANK_MAX)
//   load_value          forced level
//   fault_sel           00 none, 01 low stuck-0, 10 high stuck-1,
//                       11 middle stuck-0
//   clear_flags         clears the sticky flags
//   high/middle/low     registered level-sensor outputs
//   level               current level register
//   tick                one-cycle pulse on level update cycles
//   overflow_flag       sticky: fill attempted beyond TANK_MAX
//   dry_flag            sticky: drain attempted below 0
// -----------------------------------------------------------------------------
module tank_level_emulator #(
    parameter int LEVEL_W    = 8,
    parameter int TANK_MAX   = 200,
    parameter int INIT_LEVEL = 100,
    parameter int LOW_TH     = 40,
    parameter int MID_TH     = 100,
    parameter int HIGH_TH    = 160,
    parameter int FILL_RATE  = 4,
    parameter int SPR_RATE   = 3,
    parameter int DRIP_RATE  = 1,
    parameter int TICK_DIV   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valvula_entrada,
    input  logic               valvula_aspersao,
    input  logic               valvula_gotejamento,
    input  logic               load_en,
    input  logic [LEVEL_W-1:0] load_value,
    input  logic [1:0]         fault_sel,
    input  logic               clear_flags,
    output logic               high,
    output logic               middle,
    output logic               low,
    output logic [LEVEL_W-1:0] level,
    output logic               tick,
    output logic               overflow_flag,
    output logic               dry_flag
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int RAW_W = LEVEL_W + 2;

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [LEVEL_W-1:0] MAX_LVL   = LEVEL_W'(TANK_MAX);
    localparam logic [LEVEL_W-1:0] INIT_LVL  = LEVEL_W'(INIT_LEVEL);
    // Sensor reset value: threshold compare of INIT_LEVEL with no fault.
    localparam logic [2:0] SENS_RST = {
        (INIT_LEVEL >= HIGH_TH) ? 1'b1 : 1'b0,
        (INIT_LEVEL >= MID_TH)  ? 1'b1 : 1'b0,
        (INIT_LEVEL >= LOW_TH)  ? 1'b1 : 1'b0
    };

    // Threshold compare plus stuck-at override; returns {high, middle, low}.
    function automatic logic [2:0] sense(input logic [LEVEL_W-1:0] lvl,
                                         input logic [1:0]         fsel);
        logic [2:0] s;
        s[2] = (lvl >= LEVEL_W'(HIGH_TH)) ? 1'b1 : 1'b0;
        s[1] = (lvl >= LEVEL_W'(MID_TH))  ? 1'b1 : 1'b0;
        s[0] = (lvl >= LEVEL_W'(LOW_TH))  ? 1'b1 : 1'b0;
        case (fsel)
            2'b01:   s[0] = 1'b0;
            2'b10:   s[2] = 1'b1;
            2'b11:   s[1] = 1'b0;
            default: s    = s;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     tick_q, tick_d;
    logic [LEVEL_W-1:0]       level_q, level_d;
    logic                     ovf_q, ovf_d;
    logic                     dry_q, dry_d;
    logic [2:0]               sens_q, sens_d;
    logic signed [RAW_W-1:0]  raw_s;

    // Free-running prescaler; tick is registered so it is high exactly
    // while the count sits at its last value.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        tick_d = (cnt_d == CNT_LAST) ? 1'b1 : 1'b0;
    end

    // Net valve flow applied to the current level, kept signed with two
    // guard bits so both overshoot and undershoot are visible.
    always_comb begin
        raw_s = $signed({2'b00, level_q});
        if (valvula_entrada) begin
            raw_s = raw_s + $signed(RAW_W'(FILL_RATE));
        end else begin
            raw_s = raw_s;
        end
        if (valvula_aspersao) begin
            raw_s = raw_s - $signed(RAW_W'(SPR_RATE));
        end else begin
            raw_s = raw_s;
        end
        if (valvula_gotejamento) begin
            raw_s = raw_s - $signed(RAW_W'(DRIP_RATE));
        end else begin
            raw_s = raw_s;
        end
    end

    // Level and sticky-flag next state; load_en overrides a tick update
    // and suppresses flag setting in that cycle.
    always_comb begin
        level_d = level_q;
        ovf_d   = clear_flags ? 1'b0 : ovf_q;
        dry_d   = clear_flags ? 1'b0 : dry_q;
        if (load_en) begin
            if (load_value > MAX_LVL) begin
                level_d = MAX_LVL;
            end else begin
                level_d = load_value;
            end
        end else if (tick_q) begin
            if (raw_s > $signed(RAW_W'(TANK_MAX))) begin
                level_d = MAX_LVL;
                ovf_d   = 1'b1;
            end else if (raw_s < $signed(RAW_W'(0))) begin
                level_d = '0;
                dry_d   = 1'b1;
            end else begin
                level_d = raw_s[LEVEL_W-1:0];
            end
        end else begin
            level_d = level_q;
        end
    end

    // Sensors follow the level register one cycle later, faults included.
    always_comb begin
        sens_d = sense(level_q, fault_sel);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            level_q <= INIT_LVL;
            ovf_q   <= 1'b0;
            dry_q   <= 1'b0;
            sens_q  <= SENS_RST;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            dry_q   <= dry_d;
            sens_q  <= sens_d;
        end
    end

    assign high          = sens_q[2];
    assign middle        = sens_q[1];
    assign low           = sens_q[0];
    assign level         = level_q;
    assign tick          = tick_q;
    assign overflow_flag = ovf_q;
    assign dry_flag      = dry_q;

endmodule

// File: tb/tb_tank_level_emulator.sv
module tb_tank_level_emulator;

    logic       clk;
    logic       rst_n;
    logic       valvula_entrada;
    logic       valvula_aspersao;
    logic       valvula_gotejamento;
    logic       load_en;
    logic [7:0] load_value;
    logic [1:0] fault_sel;
    logic       clear_flags;
    logic       high;
    logic       middle;
    logic       low;
    logic [7:0] level;
    logic       tick;
    logic       overflow_flag;
    logic       dry_flag;

    int passed;
    int total;

    // Scoreboard: parallel queues of tag / observed-selector / expected value.
    string       tag_q[$];
    int          sel_q[$];
    logic [15:0] exp_q[$];

    localparam int S_LEVEL = 0;
    localparam int S_HIGH  = 1;
    localparam int S_MID   = 2;
    localparam int S_LOW   = 3;
    localparam int S_OVF   = 4;
    localparam int S_DRY   = 5;
    localparam int S_TICK  = 6;

    tank_level_emulator dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .valvula_entrada     (valvula_entrada),
        .valvula_aspersao    (valvula_aspersao),
        .valvula_gotejamento (valvula_gotejamento),
        .load_en             (load_en),
        .load_value          (load_value),
        .fault_sel           (fault_sel),
        .clear_flags         (clear_flags),
        .high                (high),
        .middle              (middle),
        .low                 (low),
        .level               (level),
        .tick                (tick),
        .overflow_flag       (overflow_flag),
        .dry_flag            (dry_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            S_LEVEL: return {8'd0, level};
            S_HIGH:  return {15'd0, high};
            S_MID:   return {15'd0, middle};
            S_LOW:   return {15'd0, low};
            S_OVF:   return {15'd0, overflow_flag};
            S_DRY:   return {15'd0, dry_flag};
            S_TICK:  return {15'd0, tick};
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [15:0] exp);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(exp);
    endtask

    // Pop every pending expectation and compare it against the DUT now.
    task automatic check_all();
        string       t;
        int          s;
        logic [15:0] e;
        logic [15:0] o;
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            o = observe(s);
            total++;
            assert (o === e) begin
                passed++;
            end else begin
                $error("FAIL %s observed=%0d expected=%0d", t, o, e);
            end
        end
    endtask

    // Wait (bounded) for a tick cycle, then step past its update edge.
    task automatic step_tick();
        for (int i = 0; i < 8; i++) begin
            if (tick === 1'b1) break;
            @(negedge clk);
        end
        push("tick_seen", S_TICK, 16'd1);
        check_all();
        @(negedge clk);
    endtask

    // Force the level through load_en for one cycle.
    task automatic load(input logic [7:0] v);
        load_en    = 1'b1;
        load_value = v;
        @(negedge clk);
        load_en    = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n = 1'b0;
        valvula_entrada = 1'b0;
        valvula_aspersao = 1'b0;
        valvula_gotejamento = 1'b0;
        load_en = 1'b0;
        load_value = 8'd0;
        fault_sel = 2'b00;
        clear_flags = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        push("rst_level", S_LEVEL, 16'd100);
        push("rst_low",   S_LOW,   16'd1);
        push("rst_mid",   S_MID,   16'd1);
        push("rst_high",  S_HIGH,  16'd0);
        push("rst_ovf",   S_OVF,   16'd0);
        push("rst_dry",   S_DRY,   16'd0);
        push("rst_tick",  S_TICK,  16'd0);
        check_all();

        // Tick pulses in cycles 4, 8, 12 after release
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            push($sformatf("tick_c%0d", k + 1), S_TICK, ((k % 4) == 3) ? 16'd1 : 16'd0);
            push("idle_level", S_LEVEL, 16'd100);
            check_all();
        end

        // Inlet only: +4 per tick up to saturation
        valvula_entrada = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            step_tick();
            push($sformatf("fill_level_t%0d", n), S_LEVEL, 16'(100 + 4 * n));
            if (n == 15) push("fill_high_lag", S_HIGH, 16'd0);
            if (n == 25) push("fill_ovf_at_max", S_OVF, 16'd0);
            check_all();
            if (n == 15) begin
                @(negedge clk);
                push("fill_high", S_HIGH, 16'd1);
                check_all();
            end
        end
        step_tick();
        push("sat_level", S_LEVEL, 16'd200);
        push("sat_ovf",   S_OVF,   16'd1);
        check_all();
        valvula_entrada = 1'b0;
        pulse_clear();
        push("ovf_cleared", S_OVF, 16'd0);
        check_all();

        // Drain below zero
        load(8'd5);
        push("load5", S_LEVEL, 16'd5);
        check_all();
        valvula_aspersao = 1'b1;
        valvula_gotejamento = 1'b1;
        step_tick();
        push("drain_1", S_LEVEL, 16'd1);
        push("drain_1_dry", S_DRY, 16'd0);
        check_all();
        step_tick();
        push("drain_0", S_LEVEL, 16'd0);
        push("drain_dry", S_DRY, 16'd1);
        check_all();
        valvula_aspersao = 1'b0;
        valvula_gotejamento = 1'b0;
        @(negedge clk);
        push("empty_low",  S_LOW,  16'd0);
        push("empty_mid",  S_MID,  16'd0);
        push("empty_high", S_HIGH, 16'd0);
        check_all();
        pulse_clear();
        push("dry_cleared", S_DRY, 16'd0);
        check_all();

        // All valves open: net zero
        load(8'd120);
        valvula_entrada = 1'b1;
        valvula_aspersao = 1'b1;
        valvula_gotejamento = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step_tick();
            push($sformatf("net0_t%0d", n), S_LEVEL, 16'd120);
            check_all();
        end
        push("net0_ovf", S_OVF, 16'd0);
        push("net0_dry", S_DRY, 16'd0);
        check_all();
        valvula_entrada = 1'b0;
        valvula_aspersao = 1'b0;
        valvula_gotejamento = 1'b0;

        // Fault injection
        load(8'd50);
        @(negedge clk);
        push("l50_low",  S_LOW,  16'd1);
        push("l50_mid",  S_MID,  16'd0);
        push("l50_high", S_HIGH, 16'd0);
        check_all();
        fault_sel = 2'b10;
        @(negedge clk);
        push("f10_high", S_HIGH, 16'd1);
        push("f10_mid",  S_MID,  16'd0);
        push("f10_low",  S_LOW,  16'd1);
        check_all();
        fault_sel = 2'b00;
        @(negedge clk);
        push("f00_high", S_HIGH, 16'd0);
        check_all();
        load(8'd120);
        @(negedge clk);
        push("l120_mid", S_MID, 16'd1);
        check_all();
        fault_sel = 2'b11;
        @(negedge clk);
        push("f11_mid", S_MID, 16'd0);
        push("f11_low", S_LOW, 16'd1);
        check_all();
        fault_sel = 2'b01;
        @(negedge clk);
        push("f01_low", S_LOW, 16'd0);
        push("f01_mid", S_MID, 16'd1);
        check_all();
        fault_sel = 2'b00;

        // load_en coincident with a tick and an open inlet
        valvula_entrada = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (tick === 1'b1) break;
            @(negedge clk);
        end
        push("load_tick_seen", S_TICK, 16'd1);
        check_all();
        load(8'd250);
        valvula_entrada = 1'b0;
        push("load_clamp", S_LEVEL, 16'd200);
        push("load_no_ovf", S_OVF, 16'd0);
        check_all();

        // Asynchronous reset mid-count
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        push("arst_level", S_LEVEL, 16'd100);
        push("arst_tick",  S_TICK,  16'd0);
        push("arst_high",  S_HIGH,  16'd0);
        push("arst_mid",   S_MID,   16'd1);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        push("restart_no_tick", S_TICK, 16'd0);
        check_all();
        @(negedge clk);
        push("restart_tick", S_TICK, 16'd1);
        check_all();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
